// File: rtl/sda_ctrl_regs_pkg.sv
// Shared constants and state encodings for the kernel control register file.
package sda_ctrl_regs_pkg;

    // CTRL register lives at byte offset 0x00 (word 0)
    localparam logic [29:0] CTRL_WORD      = 30'd0;
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_DONE_BIT  = 1;
    localparam int unsigned CTRL_IDLE_BIT  = 2;

    localparam logic [1:0]  RESP_OKAY      = 2'b00;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ACCEPT,
        RD_RESP
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ACCEPT,
        WR_RESP
    } wr_state_e;

    // GO_DACK holds done_0a until the kernel drops done_0r
    typedef enum logic [2:0] {
        GO_IDLE,
        GO_REQ,
        GO_REL,
        GO_RUN,
        GO_DACK
    } go_state_e;

    typedef enum logic {
        PRM_IDLE,
        PRM_ACK
    } prm_state_e;

endpackage

// File: rtl/sda_axi_lite_slave_if.sv
// AXI4-Lite slave front end: independent read and write channel FSMs that
// turn bus transactions into single-cycle register-file strobes.
module sda_axi_lite_slave_if (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] s_axi_araddr_i,
    input  logic        s_axi_arvalid_i,
    output logic        s_axi_arready_o,
    output logic [31:0] s_axi_rdata_o,
    output logic [1:0]  s_axi_rresp_o,
    output logic        s_axi_rvalid_o,
    input  logic        s_axi_rready_i,
    input  logic [31:0] s_axi_awaddr_i,
    input  logic        s_axi_awvalid_i,
    output logic        s_axi_awready_o,
    input  logic [31:0] s_axi_wdata_i,
    input  logic [3:0]  s_axi_wstrb_i,
    input  logic        s_axi_wvalid_i,
    output logic        s_axi_wready_o,
    output logic [1:0]  s_axi_bresp_o,
    output logic        s_axi_bvalid_o,
    input  logic        s_axi_bready_i,
    output logic        wr_en_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_strb_o,
    output logic        rd_en_o,
    output logic [31:0] rd_addr_o,
    input  logic [31:0] rd_data_i
);
    import sda_ctrl_regs_pkg::*;

    rd_state_e   rd_state_q, rd_state_d;
    wr_state_e   wr_state_q, wr_state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    // Channel state and captured beats
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_state_q <= RD_IDLE;
            wr_state_q <= WR_IDLE;
            araddr_q   <= '0;
            rdata_q    <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            araddr_q   <= araddr_d;
            rdata_q    <= rdata_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

    // Read channel: capture address, sample register file in ACCEPT, hold rvalid until rready
    always_comb begin
        rd_state_d = rd_state_q;
        araddr_d   = araddr_q;
        rdata_d    = rdata_q;
        rd_en_o    = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (s_axi_arvalid_i) begin
                    araddr_d   = s_axi_araddr_i;
                    rd_state_d = RD_ACCEPT;
                end
            end
            RD_ACCEPT: begin
                rd_en_o    = 1'b1;
                rdata_d    = rd_data_i;
                rd_state_d = RD_RESP;
            end
            RD_RESP: begin
                if (s_axi_rready_i) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Write channel: needs address and data together; one-cycle write strobe in ACCEPT
    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_en_o    = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (s_axi_awvalid_i && s_axi_wvalid_i) begin
                    awaddr_d   = s_axi_awaddr_i;
                    wdata_d    = s_axi_wdata_i;
                    wstrb_d    = s_axi_wstrb_i;
                    wr_state_d = WR_ACCEPT;
                end
            end
            WR_ACCEPT: begin
                wr_en_o    = 1'b1;
                wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                if (s_axi_bready_i) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    assign s_axi_arready_o = (rd_state_q == RD_ACCEPT);
    assign s_axi_rvalid_o  = (rd_state_q == RD_RESP);
    assign s_axi_rdata_o   = rdata_q;
    assign s_axi_rresp_o   = RESP_OKAY;
    assign rd_addr_o       = araddr_q;

    assign s_axi_awready_o = (wr_state_q == WR_ACCEPT);
    assign s_axi_wready_o  = (wr_state_q == WR_ACCEPT);
    assign s_axi_bvalid_o  = (wr_state_q == WR_RESP);
    assign s_axi_bresp_o   = RESP_OKAY;
    assign wr_addr_o       = awaddr_q;
    assign wr_data_o       = wdata_q;
    assign wr_strb_o       = wstrb_q;

endmodule

// File: rtl/sda_kernel_ctrl_regs.sv
// Host-facing control/parameter register file: AXI4-Lite slave, kernel go/done
// handshake and kernel-side parameter read port.
module sda_kernel_ctrl_regs #(
    parameter int unsigned NUM_PARAMS = 16,
    parameter logic [31:0] PARAM_BASE = 32'h10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic        go_0r,
    input  logic        go_0a,
    input  logic        done_0r,
    output logic        done_0a,
    input  logic        param_addr_0r,
    input  logic [31:0] param_addr,
    output logic        param_addr_0a,
    output logic        param_data_0r,
    output logic [31:0] param_data,
    input  logic        param_data_0a
);
    import sda_ctrl_regs_pkg::*;

    localparam int unsigned IDX_W   = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
    localparam logic [29:0] PBASE_W = PARAM_BASE[31:2];
    localparam logic [29:0] NPAR_W  = 30'(NUM_PARAMS);

    function automatic logic is_param(input logic [29:0] w);
        return (w >= PBASE_W) && ((w - PBASE_W) < NPAR_W);
    endfunction

    function automatic logic [IDX_W-1:0] param_idx(input logic [29:0] w);
        logic [29:0] off;
        off = w - PBASE_W;
        return off[IDX_W-1:0];
    endfunction

    logic        wr_en, rd_en;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [3:0]  wr_strb;

    logic [31:0] params_q [NUM_PARAMS];
    logic [31:0] params_d [NUM_PARAMS];
    go_state_e   go_q, go_d;
    logic        done_bit_q, done_bit_d;
    prm_state_e  prm_q, prm_d;
    logic        addr_ack_q, addr_ack_d;
    logic        data_vld_q, data_vld_d;
    logic [31:0] pdata_q, pdata_d;

    logic ctrl_wr, start_req, done_clr, start_busy;
    logic unused_ok;

    sda_axi_lite_slave_if u_axi (
        .clk_i           (clk),
        .reset_i         (reset),
        .s_axi_araddr_i  (s_axi_araddr),
        .s_axi_arvalid_i (s_axi_arvalid),
        .s_axi_arready_o (s_axi_arready),
        .s_axi_rdata_o   (s_axi_rdata),
        .s_axi_rresp_o   (s_axi_rresp),
        .s_axi_rvalid_o  (s_axi_rvalid),
        .s_axi_rready_i  (s_axi_rready),
        .s_axi_awaddr_i  (s_axi_awaddr),
        .s_axi_awvalid_i (s_axi_awvalid),
        .s_axi_awready_o (s_axi_awready),
        .s_axi_wdata_i   (s_axi_wdata),
        .s_axi_wstrb_i   (s_axi_wstrb),
        .s_axi_wvalid_i  (s_axi_wvalid),
        .s_axi_wready_o  (s_axi_wready),
        .s_axi_bresp_o   (s_axi_bresp),
        .s_axi_bvalid_o  (s_axi_bvalid),
        .s_axi_bready_i  (s_axi_bready),
        .wr_en_o         (wr_en),
        .wr_addr_o       (wr_addr),
        .wr_data_o       (wr_data),
        .wr_strb_o       (wr_strb),
        .rd_en_o         (rd_en),
        .rd_addr_o       (rd_addr),
        .rd_data_i       (rd_data)
    );

    // Byte-lane offset bits and the read strobe carry no information here
    assign unused_ok = ^{rd_en, rd_addr[1:0], wr_addr[1:0]};

    assign ctrl_wr    = wr_en && (wr_addr[31:2] == CTRL_WORD) && wr_strb[0];
    assign start_req  = ctrl_wr && wr_data[CTRL_START_BIT];
    assign done_clr   = ctrl_wr && wr_data[CTRL_DONE_BIT];
    assign start_busy = (go_q == GO_REQ) || (go_q == GO_REL);

    // Register read mux; sees pre-write values so same-cycle reads return old data
    always_comb begin
        rd_data = '0;
        if (rd_addr[31:2] == CTRL_WORD) begin
            rd_data[CTRL_START_BIT] = start_busy;
            rd_data[CTRL_DONE_BIT]  = done_bit_q;
            rd_data[CTRL_IDLE_BIT]  = (go_q == GO_IDLE);
        end else if (is_param(rd_addr[31:2])) begin
            rd_data = params_q[param_idx(rd_addr[31:2])];
        end
    end

    // Parameter array update with byte strobes
    always_comb begin
        params_d = params_q;
        if (wr_en && is_param(wr_addr[31:2])) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_strb[b]) params_d[param_idx(wr_addr[31:2])][8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    // Go/done handshake FSM; a DONE set in the same cycle as its W1C wins
    always_comb begin
        go_d       = go_q;
        done_bit_d = done_bit_q;
        if (done_clr) done_bit_d = 1'b0;
        case (go_q)
            GO_IDLE: if (start_req) go_d = GO_REQ;
            GO_REQ:  if (go_a_seen()) go_d = GO_REL;
            GO_REL:  if (!go_0a) go_d = GO_RUN;
            GO_RUN: begin
                if (done_0r) begin
                    go_d       = GO_DACK;
                    done_bit_d = 1'b1;
                end
            end
            GO_DACK: if (!done_0r) go_d = GO_IDLE;
            default: go_d = GO_IDLE;
        endcase
    end

    function automatic logic go_a_seen();
        return go_0a;
    endfunction

    // Kernel parameter read FSM; data latched once and held until acknowledged
    always_comb begin
        prm_d      = prm_q;
        addr_ack_d = addr_ack_q;
        data_vld_d = data_vld_q;
        pdata_d    = pdata_q;
        case (prm_q)
            PRM_IDLE: begin
                if (param_addr_0r) begin
                    pdata_d    = (param_addr < 32'(NUM_PARAMS)) ? params_q[param_addr[IDX_W-1:0]] : '0;
                    addr_ack_d = 1'b1;
                    data_vld_d = 1'b1;
                    prm_d      = PRM_ACK;
                end
            end
            PRM_ACK: begin
                if (param_data_0a)  data_vld_d = 1'b0;
                if (!param_addr_0r) addr_ack_d = 1'b0;
                if (!addr_ack_q && !data_vld_q && !param_data_0a) prm_d = PRM_IDLE;
            end
            default: prm_d = PRM_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            params_q   <= '{default: '0};
            go_q       <= GO_IDLE;
            done_bit_q <= 1'b0;
            prm_q      <= PRM_IDLE;
            addr_ack_q <= 1'b0;
            data_vld_q <= 1'b0;
            pdata_q    <= '0;
        end else begin
            params_q   <= params_d;
            go_q       <= go_d;
            done_bit_q <= done_bit_d;
            prm_q      <= prm_d;
            addr_ack_q <= addr_ack_d;
            data_vld_q <= data_vld_d;
            pdata_q    <= pdata_d;
        end
    end

    assign go_0r         = (go_q == GO_REQ);
    assign done_0a       = (go_q == GO_DACK);
    assign param_addr_0a = addr_ack_q;
    assign param_data_0r = data_vld_q;
    assign param_data    = pdata_q;

endmodule
